// File: rtl/mpd_status_if.sv
// Signal bundle between the eFPGA configuration outputs, the pad stage and the
// status controller.
interface mpd_status_if;
  logic [47:0] cfg_word;
  logic        done_override;
  logic        cfg_rx_activity;
  logic        done_led;
  logic        fabric_done;
  logic        heart_led;
  logic        rx_led;
  logic [1:0]  done_state;

  modport master (
    output cfg_word, done_override, cfg_rx_activity,
    input  done_led, fabric_done, heart_led, rx_led, done_state
  );

  modport slave (
    input  cfg_word, done_override, cfg_rx_activity,
    output done_led, fabric_done, heart_led, rx_led, done_state
  );
endinterface

// File: rtl/mpd_status_ctrl.sv
// Configuration-done qualifier and status LED driver for the MPD openframe top.
//   state | meaning
//   IDLE  | magic word not seen on the last match sample
//   QUAL  | counting consecutive matching samples
//   DONE  | configuration complete; sticky until resetn
module mpd_status_ctrl #(
  parameter logic [47:0] DONE_MAGIC       = 48'hFEEDBADCA77E,
  parameter int          DONE_QUAL_CYCLES = 16,
  parameter int          HB_FAST_HALF     = 2_500_000,
  parameter int          HB_SLOW_HALF     = 10_000_000,
  parameter int          RX_STRETCH       = 1_000_000
) (
  input logic        CLK,
  input logic        resetn,
  mpd_status_if.slave bus
);

  localparam int QW     = $clog2(DONE_QUAL_CYCLES);
  localparam int HB_MAX = (HB_FAST_HALF > HB_SLOW_HALF) ? HB_FAST_HALF : HB_SLOW_HALF;
  localparam int HW     = $clog2(HB_MAX + 1);
  localparam int RW     = $clog2(RX_STRETCH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [QW-1:0] QCNT_LAST  = QW'(DONE_QUAL_CYCLES - 1);
  localparam logic [HW-1:0] HB_FAST_M1 = HW'(HB_FAST_HALF - 1);
  localparam logic [HW-1:0] HB_SLOW_M1 = HW'(HB_SLOW_HALF - 1);
  localparam logic [RW-1:0] RX_LOAD    = RW'(RX_STRETCH);

  logic          r_ovr_s1, r_ovr_s;
  logic          r_rx_s1, r_rx_s;
  logic          r_match;
  logic [1:0]    r_state;
  logic [QW-1:0] r_qcnt;
  logic [HW-1:0] r_hcnt;
  logic          r_heart;
  logic [RW-1:0] r_rcnt;

  logic [1:0]    w_state_nxt;
  logic [QW-1:0] w_qcnt_nxt;
  logic          w_enter_done;
  logic          w_hb_last;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_ovr_s1 <= 1'b0;
      r_ovr_s  <= 1'b0;
      r_rx_s1  <= 1'b0;
      r_rx_s   <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      r_ovr_s1 <= bus.done_override;
      r_ovr_s  <= r_ovr_s1;
      r_rx_s1  <= bus.cfg_rx_activity;
      r_rx_s   <= r_rx_s1;
      r_match  <= (bus.cfg_word == DONE_MAGIC);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    case (r_state)
      ST_IDLE: begin
        if (r_match) begin
          w_state_nxt = ST_QUAL;
          w_qcnt_nxt  = QW'(1);
        end else begin
          w_qcnt_nxt  = '0;
        end
      end
      ST_QUAL: begin
        if (!r_match) begin
          w_state_nxt = ST_IDLE;
          w_qcnt_nxt  = '0;
        end else if (r_qcnt == QCNT_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_qcnt_nxt  = r_qcnt + QW'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: begin
        w_state_nxt = ST_IDLE;
        w_qcnt_nxt  = '0;
      end
    endcase
  end

  assign w_enter_done = (r_state != ST_DONE) && (w_state_nxt == ST_DONE);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_qcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
    end
  end

  // Half-period follows the current state; entering DONE restarts the slow phase high.
  assign w_hb_last = (r_state == ST_DONE) ? (r_hcnt == HB_SLOW_M1) : (r_hcnt == HB_FAST_M1);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_hcnt  <= '0;
      r_heart <= 1'b0;
    end else if (w_enter_done) begin
      r_hcnt  <= '0;
      r_heart <= 1'b1;
    end else if (w_hb_last) begin
      r_hcnt  <= '0;
      r_heart <= ~r_heart;
    end else begin
      r_hcnt  <= r_hcnt + HW'(1);
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_rcnt <= '0;
    end else if (r_rx_s) begin
      r_rcnt <= RX_LOAD;
    end else if (r_rcnt != '0) begin
      r_rcnt <= r_rcnt - RW'(1);
    end
  end

  assign bus.done_led    = (r_state == ST_DONE);
  assign bus.fabric_done = (r_state == ST_DONE) | r_ovr_s;
  assign bus.heart_led   = r_heart;
  assign bus.rx_led      = r_rx_s | (r_rcnt != '0);
  assign bus.done_state  = r_state;

endmodule

// File: tb/tb_mpd_status_ctrl.sv
// Randomized bench for mpd_status_ctrl: an edge-indexed behavioural model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mpd_status_ctrl;
  localparam logic [47:0] MAGIC = 48'hFEEDBADCA77E;
  localparam int Q   = 4;
  localparam int HBF = 4;
  localparam int HBS = 6;
  localparam int RXS = 5;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mpd_status_if bus();

  mpd_status_ctrl #(
    .DONE_MAGIC(MAGIC), .DONE_QUAL_CYCLES(Q), .HB_FAST_HALF(HBF),
    .HB_SLOW_HALF(HBS), .RX_STRETCH(RXS)
  ) dut (
    .CLK(clk), .resetn(resetn), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " done_led"},    64'(bus.done_led),    64'd0);
    chk({tag, " fabric_done"}, 64'(bus.fabric_done), 64'd0);
    chk({tag, " heart_led"},   64'(bus.heart_led),   64'd0);
    chk({tag, " rx_led"},      64'(bus.rx_led),      64'd0);
    chk({tag, " done_state"},  64'(bus.done_state),  64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: m_n is the index of the edge since reset release; each quantity is
  // derived from the samples the DUT took at earlier edges.
  int   m_n = 0, m_run = 0, m_e = 0, m_last_rx = -1000;
  bit   m_done = 0, m_ovr_prev = 0;
  logic e_done, e_fab, e_heart, e_rx;
  logic [1:0] e_state;

  always begin
    @(posedge clk);
    if (!resetn) begin
      m_n = 0; m_run = 0; m_e = 0; m_last_rx = -1000; m_done = 0; m_ovr_prev = 0;
      e_done = 0; e_fab = 0; e_heart = 0; e_rx = 0; e_state = 2'd0;
    end else begin
      m_n++;
      e_fab      = m_ovr_prev;
      m_ovr_prev = bus.done_override;
      e_rx       = ((m_n - 1 - m_last_rx) <= RXS);
      if (bus.cfg_rx_activity) m_last_rx = m_n;
      if (!m_done && m_run >= Q) begin
        m_done = 1;
        m_e    = m_n;
      end
      e_state = m_done ? 2'd2 : ((m_run >= 1) ? 2'd1 : 2'd0);
      m_run   = (bus.cfg_word == MAGIC) ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
      e_done  = m_done;
      e_fab   = e_fab | m_done;
      e_heart = m_done ? !(((m_n - m_e) / HBS) % 2) : ((m_n / HBF) % 2 == 1);
    end
    #1;
    chk("model done_led",    64'(bus.done_led),    64'(e_done));
    chk("model fabric_done", 64'(bus.fabric_done), 64'(e_fab));
    chk("model heart_led",   64'(bus.heart_led),   64'(e_heart));
    chk("model rx_led",      64'(bus.rx_led),      64'(e_rx));
    chk("model done_state",  64'(bus.done_state),  64'(e_state));
  end

  initial begin
    int first, cnt, fall, found, prob;
    logic [63:0] r64;
    bus.cfg_word        = '0;
    bus.done_override   = 1'b0;
    bus.cfg_rx_activity = 1'b0;

    repeat (3) tick();
    chk_zero("reset");
    @(negedge clk) resetn = 1'b1;

    // Fast heartbeat: toggles after edges 4, 8, ...
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) chk("hb k3", 64'(bus.heart_led), 64'd0);
      if (k == 4) chk("hb k4", 64'(bus.heart_led), 64'd1);
      if (k == 7) chk("hb k7", 64'(bus.heart_led), 64'd1);
      if (k == 8) chk("hb k8", 64'(bus.heart_led), 64'd0);
    end
    chk("idle done_led", 64'(bus.done_led), 64'd0);

    // Override held for 10 cycles
    @(negedge clk) bus.done_override = 1'b1;
    first = 0; cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.fabric_done) begin
        cnt++;
        if (first == 0) first = k;
      end
      if (bus.done_led) chk("ovr done_led", 64'(bus.done_led), 64'd0);
      if (k == 10) @(negedge clk) bus.done_override = 1'b0;
    end
    chk("ovr rise latency", 64'(first), 64'd2);
    chk("ovr high cycles",  64'(cnt),   64'd10);

    // rx pulse of 3 cycles
    @(negedge clk) bus.cfg_rx_activity = 1'b1;
    first = 0; fall = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.rx_led && first == 0) first = k;
      if (!bus.rx_led && first != 0 && fall == 0) fall = k;
      if (k == 3) @(negedge clk) bus.cfg_rx_activity = 1'b0;
    end
    chk("rx rise latency", 64'(first), 64'd2);
    chk("rx fall edge",    64'(fall),  64'd10);

    // Magic for 3 cycles, one near-miss word, then magic again
    @(negedge clk) bus.cfg_word = MAGIC;
    repeat (3) tick();
    @(negedge clk) bus.cfg_word = MAGIC | 48'h1;
    tick();
    chk("glitch qual state", 64'(bus.done_state), 64'd1);
    @(negedge clk) bus.cfg_word = MAGIC;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) chk("glitch back to idle", 64'(bus.done_state), 64'd0);
      if (bus.done_led) begin
        found = k;
        break;
      end
    end
    chk("done latency",     64'(found),          64'd5);
    chk("done state",       64'(bus.done_state), 64'd2);
    chk("heart on entry",   64'(bus.heart_led),  64'd1);
    for (int j = 1; j <= 6; j++) begin
      tick();
      if (j == 5) chk("slow hb j5", 64'(bus.heart_led), 64'd1);
      if (j == 6) chk("slow hb j6", 64'(bus.heart_led), 64'd0);
    end
    @(negedge clk) bus.cfg_word = '0;
    repeat (10) tick();
    chk("done sticky", 64'(bus.done_led), 64'd1);

    // Asynchronous reset in the middle of a cycle
    @(negedge clk) resetn = 1'b0;
    #1 chk_zero("async reset");
    tick();
    @(negedge clk) resetn = 1'b1;

    // Randomized traffic with occasional resets and varying match density
    prob = 80;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(299, 0) == 0) begin
        resetn = 1'b0;
        #1 chk_zero("rand reset");
        prob = 30 * $urandom_range(3, 1);
        @(negedge clk);
        resetn = 1'b1;
      end
      r64 = {$urandom(), $urandom()};
      if ($urandom_range(99, 0) < prob) bus.cfg_word = MAGIC;
      else if ($urandom_range(1, 0) == 1) bus.cfg_word = MAGIC ^ (48'h1 << $urandom_range(47, 0));
      else bus.cfg_word = r64[47:0];
      if ($urandom_range(15, 0) == 0) bus.done_override = ~bus.done_override;
      if ($urandom_range(7, 0) == 0)  bus.cfg_rx_activity = ~bus.cfg_rx_activity;
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mpd_status_ctrl.md
# mpd_status_ctrl

Status and configuration-done controller for the MPD openframe FPGA top. Sits between the eFPGA configuration outputs and the GPIO pad control stage. Qualifies the 48-bit configuration-done magic word, merges it with the external done override, and produces `fabric_done` for the per-pad IO controllers. Also drives the three status LED outputs on GPIO[6:4]: DONE, heartbeat and receive activity.

## Interface
Parameters:
- `DONE_MAGIC`, 48'hFEEDBADCA77E, value of `cfg_word` that marks configuration complete.
- `DONE_QUAL_CYCLES`, 16, consecutive matching samples required before done asserts (legal range >= 2).
- `HB_FAST_HALF`, 2_500_000, heartbeat half-period in cycles while not done (legal range >= 1).
- `HB_SLOW_HALF`, 10_000_000, heartbeat half-period in cycles once done (legal range >= 1).
- `RX_STRETCH`, 1_000_000, number of cycles `rx_led` is held after receive activity ends (legal range >= 1).

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: fabric clock.
- `resetn` in 1: asynchronous active-low reset.
- `cfg_word` in 48: {D_config_west_C[23:0], C_config_west_C[23:0]}. Quasi-static latch outputs.
- `done_override` in 1: raw pad input GPIO[1], asynchronous.
- `cfg_rx_activity` in 1: raw ReceiveLED level from the config engine, asynchronous.
- `done_led` out 1: qualified, sticky configuration done.
- `fabric_done` out 1: `done_led` OR synchronized override; drives the IO controllers.
- `heart_led` out 1: heartbeat.
- `rx_led` out 1: stretched receive activity.
- `done_state` out 2: FSM state for debug (0 IDLE, 1 QUAL, 2 DONE).

## Operation
- Synchronizers: `done_override` and `cfg_rx_activity` each pass through 2 flops (`ovr_s`, `rx_s`). Reset value of all sync flops is 0.
- Match register: `match_q <= (cfg_word == DONE_MAGIC)` every cycle.
- Done FSM, `qcnt` width $clog2(DONE_QUAL_CYCLES):
  - IDLE: if `match_q`, go to QUAL with qcnt=1. Otherwise stay in IDLE with qcnt=0.
  - QUAL: if `!match_q`, go to IDLE with qcnt=0. Else if qcnt==DONE_QUAL_CYCLES-1, go to DONE. Else qcnt++.
  - DONE: terminal. It is left only by `resetn`, and later `cfg_word` changes are ignored.
  - Encoding 3 is unreachable. If it occurs, the next state is IDLE.
- `done_led` = (state==DONE), taken from the state register.
- `fabric_done` = `done_led` | `ovr_s`. The OR is combinational on registered signals. The override does not affect the FSM.
- Heartbeat: `hcnt` is sized for max(HB_FAST_HALF, HB_SLOW_HALF).
  - The active half-period is HB_SLOW_HALF in DONE, otherwise HB_FAST_HALF.
  - When hcnt == half-1: hcnt clears and `heart_led` toggles. Otherwise hcnt++.
  - On the cycle the FSM enters DONE: hcnt clears and `heart_led` is forced to 1. This overrides the toggle.
- Receive stretch:
  - While `rx_s`=1, `rcnt` loads RX_STRETCH.
  - While `rx_s`=0 and rcnt!=0, rcnt decrements.
  - `rx_led` = `rx_s` | (rcnt!=0), combinational.

## Timing
- Reset values: state IDLE, qcnt 0, match_q 0, hcnt 0, rcnt 0. Outputs: `done_led` 0, `fabric_done` 0, `heart_led` 0, `rx_led` 0, `done_state` 0.
- Done latency: suppose `cfg_word` becomes the magic value before edge N, which sets match_q=1. With continuous matching, `done_led` rises after edge N+DONE_QUAL_CYCLES. With the default that is 17 edges after the word is applied.
- A single non-matching `match_q` sample during QUAL restarts qualification from IDLE.
- Override latency: `fabric_done` rises 2 edges after `done_override` rises, and falls 2 edges after it falls, unless `done_led`=1.
- Heartbeat: when not done, `heart_led` first toggles after edge HB_FAST_HALF and then every HB_FAST_HALF edges. Period is 2*HB_FAST_HALF.
- rx latency: `rx_led` rises 2 edges after `cfg_rx_activity` rises. It falls RX_STRETCH+2 edges after `cfg_rx_activity` falls.
- Simultaneous events: a DONE entry coinciding with a heartbeat toggle gives `heart_led`=1.
- An rx pulse shorter than 1 cycle may be missed. No requirement applies to such pulses.
- Reset mid-operation: asserting `resetn` low at any time returns all state to reset values immediately. This includes DONE.

## Test plan
- Reset release with `cfg_word`=0 and HB_FAST_HALF=4: `done_led`=0 and `fabric_done`=0 throughout. `heart_led` toggles every 4 cycles, giving an 8-cycle period.
- Apply 48'hFEEDBADCA77E with DONE_QUAL_CYCLES=4: `done_led` rises exactly 5 edges later. `done_state`=2. `heart_led`=1 on entry, then toggles every HB_SLOW_HALF=6 cycles.
- Apply magic for 3 cycles, then 48'hFEEDBADCA77F for 1 cycle, then magic again (Q=4): the FSM returns to IDLE. `done_led` rises 5 edges after the second application.
- Reach DONE, then set `cfg_word`=0: `done_led` stays 1. Pulse `resetn` low mid-count: all outputs are 0 immediately.
- Drive `done_override` 1 for 10 cycles with no magic: `fabric_done` is high for 10 cycles, delayed by 2. `done_led` stays 0.
- Drive `cfg_rx_activity` high for 3 cycles with RX_STRETCH=5: `rx_led` rises 2 edges after the rise and falls 7 edges after the input falls.
